trng_xor_sampler_ctrl: RTL

- Controller for the ring-oscillator XOR tree entropy source.
- Gates the oscillator bank and waits for a warm-up period.
- Samples the asynchronous tree output at a programmable rate, with optional von Neumann debiasing.
- Packs bits into WIDTH-bit words and hands them to the bus-side consumer over a valid/ready handshake.

---
 rtl/trng_pkg.sv | 15 +
 rtl/trng_sync_2ff.sv | 25 ++
 rtl/vn_debias.sv | 43 ++++
 rtl/trng_xor_sampler_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG XOR-tree sampler controller.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FULL   = 2'd3
    } trng_state_e;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_WARMUP_CYCLES = 1024;
    localparam int DEF_DIV_W         = 8;

endpackage

// File: rtl/trng_sync_2ff.sv
// Two-flop synchronizer cell for a single asynchronous level.
module trng_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give metastability time before the value is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vn_debias.sv
// Von Neumann pair filter: emits the first bit of a 01/10 pair, drops 00/11.
module vn_debias (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic smp_stb_i,
    input  logic smp_bit_i,
    output logic out_valid_o,
    output logic out_bit_o
);

    logic pair_q, pair_d;
    logic first_q, first_d;

    // Track whether the next strobe completes a pair; remember the first bit.
    always_comb begin
        pair_d  = pair_q;
        first_d = first_q;
        if (clr_i) begin
            pair_d = 1'b0;
        end else if (smp_stb_i) begin
            pair_d = ~pair_q;
            if (!pair_q) begin
                first_d = smp_bit_i;
            end
        end
    end

    // Pair flag and first-bit storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            first_q <= first_d;
        end
    end

    assign out_valid_o = smp_stb_i & pair_q & ~clr_i & (first_q ^ smp_bit_i);
    assign out_bit_o   = first_q;

endmodule

// File: rtl/trng_xor_sampler_ctrl.sv
// Ring-oscillator XOR tree controller: warm-up, paced sampling, optional
// von Neumann debiasing, word packing and valid/ready hand-off.
//
// state  | meaning
// IDLE   | oscillators off, waiting for enable
// WARMUP | oscillators on, counting down the settle time
// SAMPLE | taking one sample every div_q+1 cycles into the shift register
// FULL   | word complete, waiting for the output register to be free
module trng_xor_sampler_ctrl
    import trng_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int DIV_W         = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             debias_en,
    input  logic [DIV_W-1:0] div,
    input  logic             xor_raw,
    output logic             osc_en,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);

    trng_state_e        state_q, state_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [DIV_W-1:0]   int_cnt_q, int_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               deb_q, deb_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   rnd_data_q, rnd_data_d;
    logic               rnd_valid_q, rnd_valid_d;

    logic sync_q;
    logic smp_stb;
    logic vn_valid, vn_bit;
    logic shift_en, shift_bit;
    logic start_word;

    trng_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (xor_raw),
        .q_o   (sync_q)
    );

    assign smp_stb = (state_q == ST_SAMPLE) && (int_cnt_q == '0);

    // Pair flag is held clear outside SAMPLE so every word starts on a pair boundary.
    vn_debias u_vn (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (state_q != ST_SAMPLE),
        .smp_stb_i   (smp_stb),
        .smp_bit_i   (sync_q),
        .out_valid_o (vn_valid),
        .out_bit_o   (vn_bit)
    );

    assign shift_en  = deb_q ? vn_valid : smp_stb;
    assign shift_bit = deb_q ? vn_bit : sync_q;

    // Next-state, counters, packing and output-register load.
    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        int_cnt_d   = int_cnt_q;
        div_d       = div_q;
        deb_d       = deb_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rnd_data_d  = rnd_data_q;
        rnd_valid_d = rnd_valid_q & ~rnd_ready;
        start_word  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_WARMUP;
                    warm_cnt_d = WARM_W'(WARMUP_CYCLES - 1);
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (warm_cnt_q == '0) begin
                    state_d    = ST_SAMPLE;
                    start_word = 1'b1;
                end else begin
                    warm_cnt_d = warm_cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    int_cnt_d = (int_cnt_q == '0) ? div_q : int_cnt_q - 1'b1;
                    if (shift_en) begin
                        shreg_d   = {shreg_q[WIDTH-2:0], shift_bit};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_d = ST_FULL;
                        end
                    end
                end
            end
            ST_FULL: begin
                // A same-cycle handshake frees the output register for this word.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!rnd_valid_q || rnd_ready) begin
                    rnd_data_d  = shreg_q;
                    rnd_valid_d = 1'b1;
                    state_d     = ST_SAMPLE;
                    start_word  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_word) begin
            div_d     = div;
            deb_d     = debias_en;
            int_cnt_d = div;
            bit_cnt_d = '0;
            shreg_d   = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            warm_cnt_q  <= '0;
            int_cnt_q   <= '0;
            div_q       <= '0;
            deb_q       <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            int_cnt_q   <= int_cnt_d;
            div_q       <= div_d;
            deb_q       <= deb_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rnd_data_q  <= rnd_data_d;
            rnd_valid_q <= rnd_valid_d;
        end
    end

    assign osc_en    = (state_q != ST_IDLE);
    assign busy      = (state_q == ST_WARMUP) || (state_q == ST_SAMPLE);
    assign rnd_data  = rnd_data_q;
    assign rnd_valid = rnd_valid_q;

endmodule
